// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered (non fall-through) read data.
// Define FIFO_STATUS_EN to add the count, overflow and underflow status outputs.
module fifo #(
  parameter int unsigned X     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [X-1:0] din,
  output logic [X-1:0] dout,
  output logic         full,
`ifdef FIFO_STATUS_EN
  output logic [AW:0]  count,
  output logic         overflow,
  output logic         underflow,
`endif
  output logic         empty
);

  logic [X-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [X-1:0] dout_q, dout_d;
  logic         wr_acc, rd_acc;

  // The extra pointer bit separates the full case from the empty case.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // A read frees a slot in the same cycle, so a write to a full FIFO is allowed alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem[wptr_q[AW-1:0]] <= din;
  end

  assign dout = dout_q;

`ifdef FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  assign count = wptr_q - rptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full && !rd_acc) overflow_q <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo;
  localparam int unsigned X     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [X-1:0] din;
  logic [X-1:0] dout;
  logic         full;
  logic         empty;
`ifdef FIFO_STATUS_EN
  logic [AW:0]  count;
  logic         overflow;
  logic         underflow;
`endif

  fifo #(.X(X), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .din      (din),
    .dout     (dout),
    .full     (full),
`ifdef FIFO_STATUS_EN
    .count    (count),
    .overflow (overflow),
    .underflow(underflow),
`endif
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a queue of stored words plus the expected output register.
  logic [X-1:0] q[$];
  logic [X-1:0] m_dout;
  bit           m_ovf;
  bit           m_unf;

  task automatic cycle(input bit w, input bit r, input logic [X-1:0] d);
    bit ra;
    bit wa;
    ra = r && (q.size() != 0);
    wa = w && ((q.size() < DEPTH) || ra);
    if (w && (q.size() == DEPTH) && !ra) m_ovf = 1'b1;
    if (r && (q.size() == 0)) m_unf = 1'b1;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; din = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b1; wr_en = 1'b0;
    model_reset();
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_total++; if (dout !== 4'h0) $display("FAIL reset_dout: got %h expected 0", dout); else n_pass++;
`ifdef FIFO_STATUS_EN
    n_total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
`endif
    cycle(1'b0, 1'b0, 4'h0);
    n_total++; if (empty !== 1'b1) $display("FAIL reset_priority: got empty=%b expected 1", empty); else n_pass++;
  endtask

  task automatic test_fill();
    logic [X-1:0] vals [4];
    vals = '{4'h3, 4'h9, 4'hC, 4'h5};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, vals[i]);
      n_total++;
      if (empty !== 1'b0) $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty);
      else n_pass++;
      n_total++;
      if (full !== (q.size() == DEPTH))
        $display("FAIL fill_full[%0d]: got %b expected %b", i, full, q.size() == DEPTH);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 4'hF);
    n_total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", full); else n_pass++;
    n_total++; if (dout !== m_dout) $display("FAIL ovf_dout: got %h expected %h", dout, m_dout); else n_pass++;
`ifdef FIFO_STATUS_EN
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
    n_total++; if (count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", count); else n_pass++;
`endif
  endtask

  task automatic test_drain();
    logic [X-1:0] exp_vals [4];
    exp_vals = '{4'h3, 4'h9, 4'hC, 4'h5};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'h0);
      n_total++;
      if (dout !== exp_vals[i]) $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, exp_vals[i]);
      else n_pass++;
    end
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
    cycle(1'b0, 1'b1, 4'h0);
    n_total++; if (dout !== 4'h5) $display("FAIL drain_extra_read: got %h expected 5", dout); else n_pass++;
`ifdef FIFO_STATUS_EN
    n_total++; if (underflow !== 1'b1) $display("FAIL underflow_flag: got %b expected 1", underflow); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    // Simultaneous read and write on an empty FIFO only writes.
    cycle(1'b1, 1'b1, 4'hA);
    n_total++; if (empty !== 1'b0) $display("FAIL rw_empty_empty: got %b expected 0", empty); else n_pass++;
    n_total++; if (dout !== m_dout) $display("FAIL rw_empty_dout: got %h expected %h", dout, m_dout); else n_pass++;
    cycle(1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b0, 4'h1);
    cycle(1'b1, 1'b0, 4'h2);
    cycle(1'b1, 1'b1, 4'h7);
    n_total++; if (dout !== 4'h1) $display("FAIL simul_dout: got %h expected 1", dout); else n_pass++;
    n_total++;
    if (empty !== 1'b0 || full !== 1'b0) $display("FAIL simul_flags: got e=%b f=%b expected e=0 f=0", empty, full);
    else n_pass++;
`ifdef FIFO_STATUS_EN
    n_total++; if (count !== 3'd2) $display("FAIL simul_count: got %0d expected 2", count); else n_pass++;
`endif
    // Fill, then read and write together while full.
    cycle(1'b1, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 4'h9);
    cycle(1'b1, 1'b1, 4'hB);
    n_total++; if (full !== 1'b1) $display("FAIL simul_full: got %b expected 1", full); else n_pass++;
    n_total++; if (dout !== m_dout) $display("FAIL simul_full_dout: got %h expected %h", dout, m_dout); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), X'($urandom));
      n_total++;
      if (dout !== m_dout || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got dout=%h e=%b f=%b expected dout=%h e=%b f=%b", i, dout,
                   empty, full, m_dout, q.size() == 0, q.size() == DEPTH);
        errs++;
      end else n_pass++;
`ifdef FIFO_STATUS_EN
      n_total++;
      if (count !== 3'(q.size()) || overflow !== m_ovf || underflow !== m_unf)
        $display("FAIL random_status[%0d]: got c=%0d o=%b u=%b expected c=%0d o=%b u=%b", i, count,
                 overflow, underflow, q.size(), m_ovf, m_unf);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 4'h6);
    cycle(1'b1, 1'b0, 4'hD);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    n_total++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL midrst_full: got %b expected 0", full); else n_pass++;
    n_total++; if (dout !== 4'h0) $display("FAIL midrst_dout: got %h expected 0", dout); else n_pass++;
    cycle(1'b0, 1'b1, 4'h0);
    n_total++;
    if (dout !== 4'h0 || empty !== 1'b1) $display("FAIL midrst_read: got dout=%h e=%b expected 0/1", dout, empty);
    else n_pass++;
`ifdef FIFO_STATUS_EN
    n_total++; if (overflow !== 1'b0) $display("FAIL midrst_ovf: got %b expected 0", overflow); else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
